// File: rtl/multi_button_conditioner.sv
// Multi-channel push-button conditioner: per-channel synchroniser, counter debouncer,
// press/release one-shots, long-press detection and auto-repeat, all in the clk domain.
module multi_button_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_BITS       = 3,
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int LONG_CYCLES     = 27_000_000,
    parameter int REPEAT_CYCLES   = 6_750_000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_N   = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] REPEAT_N = HOLD_W'(REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

    logic [CHANNELS-1:0] button_act;

    // Everything downstream of this point is active-high.
    assign button_act = button ^ {CHANNELS{ACTIVE_LOW}};

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_BITS-1:0] sync_q;
        logic [DB_W-1:0]      db_cnt_q;
        logic                 level_q;
        logic                 press_q;
        logic                 release_q;
        logic                 synced;
        logic                 flip;
        hold_state_t          state_q;
        hold_state_t          state_d;
        logic [HOLD_W-1:0]    hold_cnt_q;
        logic [HOLD_W-1:0]    hold_cnt_d;
        logic                 long_hit;
        logic                 repeat_hit;

        assign synced = sync_q[SYNC_BITS-1];
        assign flip   = (synced != level_q) && (db_cnt_q == DB_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q    <= '0;
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_BITS-2:0], button_act[ch]};
                if (synced == level_q || flip) begin
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
                if (flip) begin
                    level_q <= ~level_q;
                end
                press_q   <= flip && !level_q;
                release_q <= flip && level_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= IDLE;
                hold_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
            end
        end

        // Pulses decode registered state and are gated by level, so a release that
        // lands on a long/repeat boundary suppresses that pulse in the same cycle.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            long_hit   = 1'b0;
            repeat_hit = 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_q) begin
                        state_d    = HELD;
                        hold_cnt_d = HOLD_ONE;
                    end
                end
                HELD: begin
                    if (hold_cnt_q == LONG_N) begin
                        long_hit   = 1'b1;
                        hold_cnt_d = HOLD_ONE;
                        state_d    = REPEAT;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (REPEAT_CYCLES != 0) begin
                        if (hold_cnt_q == REPEAT_N) begin
                            repeat_hit = 1'b1;
                            hold_cnt_d = HOLD_ONE;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            endcase
            if (!level_q && state_q != IDLE) begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                long_hit   = 1'b0;
                repeat_hit = 1'b0;
            end
        end

        assign level[ch]         = level_q;
        assign press[ch]         = press_q;
        assign release_pulse[ch] = release_q;
        assign long_press[ch]    = long_hit;
        assign repeat_pulse[ch]  = repeat_hit;
    end

endmodule

// File: doc/multi_button_conditioner.md
Name: multi_button_conditioner

Overview:
- Parametrised, multi-channel successor to the single-button sync/debounce/one-shot chain.
- Per channel: synchroniser, then counter-based debouncer, then press/release one-shots, long-press detection and auto-repeat.
- Sits between board push-buttons and control logic (acquisition start/stop, mode select). Each event is a single-cycle pulse in the `clk` domain.

Parameters:
- CHANNELS, 4: number of independent button inputs (≥1).
- SYNC_BITS, 3: synchroniser flop depth (≥2).
- DEBOUNCE_CYCLES, 64: consecutive cycles of disagreement required before the debounced level flips (≥2).
- LONG_CYCLES, 27_000_000: cycles from the press pulse to the long_press pulse (≥1).
- REPEAT_CYCLES, 6_750_000: auto-repeat period after long_press. 0 disables repeat.
- ACTIVE_LOW, 0: 1 means the raw inputs are active-low and are inverted before the synchroniser.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- button  in  CHANNELS  raw asynchronous button inputs.
- level  out  CHANNELS  debounced, active-high pressed state.
- press  out  CHANNELS  1-cycle pulse on the debounced rising edge.
- release  out  CHANNELS  1-cycle pulse on the debounced falling edge.
- long_press  out  CHANNELS  1-cycle pulse once per hold, when the hold reaches LONG_CYCLES.
- repeat  out  CHANNELS  1-cycle pulse every REPEAT_CYCLES after long_press while still held.

Behaviour:
- Reset:
  - All outputs are 0, all counters are 0, and every FSM is in IDLE.
  - Synchroniser flops reset to the inactive (post-inversion 0) value, so no spurious press is generated on reset release.
  - Reset takes effect immediately, including mid-debounce or mid-hold.
- Polarity: when ACTIVE_LOW=1, each input is inverted before the synchroniser. All internal logic and all outputs are active-high.
- Synchroniser: a SYNC_BITS-deep shift register per channel. s = last stage.
- Debouncer (per channel), counter width $clog2(DEBOUNCE_CYCLES):
  - If s == level, the counter clears to 0.
  - If s != level and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If s != level and counter == DEBOUNCE_CYCLES-1, level toggles and the counter clears.
- Latency: if an input changes before edge E1 and then stays stable, level changes on edge E(SYNC_BITS + DEBOUNCE_CYCLES). Any shorter excursion produces no output change.
- press/release are registered and assert in the same cycle as level's first cycle at its new value. Each lasts exactly 1 cycle.
- Hold FSM (per channel):
  - States: IDLE, HELD, REPEAT.
  - Hold counter width is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1).
  - IDLE → HELD on the press pulse; the counter loads 1.
  - HELD: the counter increments each cycle while level=1. When the counter == LONG_CYCLES, long_press pulses, the counter loads 1, and the FSM goes to REPEAT.
  - REPEAT, REPEAT_CYCLES>0: when the counter == REPEAT_CYCLES, repeat pulses and the counter loads 1; otherwise it increments.
  - REPEAT, REPEAT_CYCLES=0: the counter holds and repeat is never asserted.
  - Any state → IDLE when level falls; the counter clears.
- Timing: long_press is asserted exactly LONG_CYCLES cycles after press. Successive repeat pulses are exactly REPEAT_CYCLES apart. The first repeat comes REPEAT_CYCLES cycles after long_press.
- Simultaneous events:
  - If level falls on the same edge a long_press or repeat would fire, release wins and the long_press/repeat is suppressed.
  - press and release can never be high together on one channel.
- Channels are fully independent. Any combination of channels may pulse in the same cycle.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-hold on channel 0 (level=1, FSM in REPEAT) → all outputs 0 in the same cycle. After deassert with button still high, press fires again only after SYNC_BITS + DEBOUNCE_CYCLES edges.
- Clean press, with SYNC_BITS=3, DEBOUNCE_CYCLES=4: button[0] rises before E1 → level[0] and press[0] go high after E7. press[0] is high for exactly 1 cycle. Other channels stay 0.
- Bounce: pulse button[1] high for 3 cycles, low for 2, high for 3, then low, with DEBOUNCE_CYCLES=4 → level, press and release stay 0 throughout. A subsequent 10-cycle high → exactly one press and one release.
- Long press and repeat, with LONG_CYCLES=20, REPEAT_CYCLES=5, held for 40 cycles after press:
  - long_press occurs at press+20.
  - repeat occurs at press+25, +30, +35, +40 as long as level=1.
  - release follows the debounced fall.
  - Rerun with REPEAT_CYCLES=0 → no repeat pulses.
- Release collision: time the button fall so level drops on the edge at press+20 → release=1, long_press=0 in that cycle, FSM returns to IDLE.
- Multi-channel with ACTIVE_LOW=1: drive channels 2 and 3 low simultaneously, with channels 0 and 1 held high → press[2] and press[3] pulse in the same cycle, press[0] and press[1] never pulse, and after reset no output asserts while all inputs are high.
